// File: rtl/seg_scan_pkg.sv
// Shared seven-segment display definitions: segment bit positions, digit
// glyphs (logical 1 = lit, bit7..bit0 = A..G,DP) and the scan state encoding.
package seg_scan_pkg;

  // Segment bit positions inside a display byte
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Decimal glyphs, shared with the segment decoder
  localparam logic [7:0] GLYPH_ZERO  = 8'hFC;
  localparam logic [7:0] GLYPH_ONE   = 8'h60;
  localparam logic [7:0] GLYPH_TWO   = 8'hDA;
  localparam logic [7:0] GLYPH_THREE = 8'hF2;
  localparam logic [7:0] GLYPH_FOUR  = 8'h66;
  localparam logic [7:0] GLYPH_FIVE  = 8'hB6;
  localparam logic [7:0] GLYPH_SIX   = 8'hBE;
  localparam logic [7:0] GLYPH_SEVEN = 8'hE0;
  localparam logic [7:0] GLYPH_EIGHT = 8'hFE;
  localparam logic [7:0] GLYPH_NINE  = 8'hF6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_if.sv
// Segment word handshake: producer (master) offers seg_word with seg_valid,
// consumer (slave) accepts while seg_ready is high.
//   seg_word  : byte k drives digit k (digit 0 = bits 7:0)
//   seg_valid : word offered
//   seg_ready : consumer shadow register free
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [8*NUM_DIGITS-1:0] seg_word;
  logic                    seg_valid;
  logic                    seg_ready;

  modport master (output seg_word, output seg_valid, input seg_ready);
  modport slave  (input seg_word, input seg_valid, output seg_ready);

endinterface

// File: rtl/seg_scan_timer.sv
// Scan sequencer: tick/digit counter pair and IDLE/BLANK/SHOW state.
//   clk, rst_n      : clock, async active-low reset
//   enable_i        : 1 = scan, 0 = return to IDLE
//   state_o         : current phase
//   digit_o         : current digit index
//   frame_start_c_o : current cycle is the first cycle of the digit-0 slot
//   frame_end_c_o   : current cycle is a frame boundary (last slot cycle or IDLE)
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS  = 4,
  parameter  int unsigned DIGIT_TICKS = 50000,
  parameter  int unsigned BLANK_TICKS = 500,
  localparam int unsigned DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned TICK_W      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output scan_state_e       state_o,
  output logic [DIG_W-1:0]  digit_o,
  output logic              frame_start_c_o,
  output logic              frame_end_c_o
);

  // First phase of every slot; with no blanking a slot opens lit
  localparam scan_state_e SLOT_START = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;

  scan_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic              slot_end_c;
  logic              last_digit_c;

  assign slot_end_c   = (tick_q == TICK_W'(DIGIT_TICKS - 1));
  assign last_digit_c = (digit_q == DIG_W'(NUM_DIGITS - 1));

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      digit_q <= digit_d;
    end
  end

  // Next-state: disable aborts the slot at once, no partial completion
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    digit_d = digit_q;
    unique case (state_q)
      ST_IDLE: begin
        tick_d  = '0;
        digit_d = '0;
        if (enable_i) state_d = SLOT_START;
      end
      ST_BLANK, ST_SHOW: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          tick_d  = '0;
          digit_d = '0;
        end else if (slot_end_c) begin
          state_d = SLOT_START;
          tick_d  = '0;
          digit_d = last_digit_c ? '0 : digit_q + DIG_W'(1);
        end else begin
          tick_d  = tick_q + TICK_W'(1);
          state_d = ((32'(tick_q) + 32'd1) >= BLANK_TICKS) ? ST_SHOW : ST_BLANK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        digit_d = '0;
      end
    endcase
  end

  assign state_o         = state_q;
  assign digit_o         = digit_q;
  assign frame_start_c_o = (state_q != ST_IDLE) && (tick_q == '0) && (digit_q == '0);
  assign frame_end_c_o   = (state_q == ST_IDLE) || (slot_end_c && last_digit_c);

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment driver with frame-synchronous word update.
//   clk, rst_n : clock, async active-low reset
//   enable     : 1 = scan, 0 = display dark
//   seg_bus    : slave side of the segment word valid/ready handshake
//   seg_pins   : segment pins A..DP (bit7 = A), registered, polarity applied
//   dig_pins   : one-hot digit select, registered, polarity applied
//   frame_tick : one-cycle pulse aligned with digit 0's first slot cycle on the pins
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS     = 4,
  parameter  int unsigned DIGIT_TICKS    = 50000,
  parameter  int unsigned BLANK_TICKS    = 500,
  parameter  bit          SEG_ACTIVE_LOW = 1'b1,
  parameter  bit          DIG_ACTIVE_LOW = 1'b1,
  localparam int unsigned DIG_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_if.slave             seg_bus,
  output logic [7:0]            seg_pins,
  output logic [NUM_DIGITS-1:0] dig_pins,
  output logic                  frame_tick
);

  // Inactive pin levels; XOR with these also applies polarity to a lit pattern
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  scan_state_e                state;
  logic [DIG_W-1:0]           digit;
  logic                       frame_start_c;
  logic                       frame_end_c;
  logic                       xfer_c;

  logic [NUM_DIGITS-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][7:0] active_q, active_d;
  logic                       pending_q, pending_d;
  logic [7:0]                 seg_pins_q, seg_pins_d;
  logic [NUM_DIGITS-1:0]      dig_pins_q, dig_pins_d;
  logic                       frame_tick_q, frame_tick_d;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIGIT_TICKS (DIGIT_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) u_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable),
    .state_o         (state),
    .digit_o         (digit),
    .frame_start_c_o (frame_start_c),
    .frame_end_c_o   (frame_end_c)
  );

  // Word and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_pins_q   <= SEG_OFF;
      dig_pins_q   <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_pins_q   <= seg_pins_d;
      dig_pins_q   <= dig_pins_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Transfer only into an empty shadow, so a same-cycle boundary never sees the
  // incoming word: it waits for the following boundary.
  always_comb begin
    xfer_c       = seg_bus.seg_valid && !pending_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    seg_pins_d   = SEG_OFF;
    dig_pins_d   = DIG_OFF;
    frame_tick_d = frame_start_c;

    if (frame_end_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (xfer_c) begin
      shadow_d  = seg_bus.seg_word;
      pending_d = 1'b1;
    end

    if (state == ST_SHOW) begin
      seg_pins_d = active_q[digit] ^ SEG_OFF;
      dig_pins_d = (NUM_DIGITS'(1) << digit) ^ DIG_OFF;
    end
  end

  assign seg_bus.seg_ready = ~pending_q;
  assign seg_pins          = seg_pins_q;
  assign dig_pins          = dig_pins_q;
  assign frame_tick        = frame_tick_q;

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Multiplexed seven-segment display driver: the consumer end of the 32-bit packed segment word produced by the timer segment decoder.
- Accepts a 4-digit x 8-bit segment word through a valid/ready handshake and holds it in a shadow register.
- Applies the shadow word only at frame boundaries, so a frame never mixes old and new digits.
- Time-multiplexes digit enables with blanking dead-time to suppress ghosting; drives the board segment and digit-select pins directly.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; word width is 8*NUM_DIGITS.
- DIGIT_TICKS, 50000, clk cycles per digit slot (1 ms at 50 MHz); >= 2.
- BLANK_TICKS, 500, blanked cycles at the start of each slot; 0 <= BLANK_TICKS < DIGIT_TICKS.
- SEG_ACTIVE_LOW, 1, 1 = segment pins low-true.
- DIG_ACTIVE_LOW, 1, 1 = digit-select pins low-true.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan, 0 = display dark.
- seg_word  in  8*NUM_DIGITS  byte k drives digit k (digit 0 = bits 7:0, rightmost). Byte format: bit7..bit0 = A,B,C,D,E,F,G,DP, logical 1 = lit.
- seg_valid  in  1  seg_word is offered.
- seg_ready  out  1  shadow register free.
- seg_pins  out  8  segment pins A..DP (bit7 = A), polarity per SEG_ACTIVE_LOW.
- dig_pins  out  NUM_DIGITS  one-hot digit select, polarity per DIG_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse when a new frame starts.

Behaviour:
- Reset (async assert, sync release):
  - seg_pins and dig_pins all inactive (all-1 with default parameters).
  - seg_ready=1, frame_tick=0.
  - Active word = 0 (blank), shadow empty, digit index 0, tick counter 0, state IDLE.
- Handshake:
  - Transfer when seg_valid && seg_ready: shadow <= seg_word, pending <= 1, seg_ready = 0 from the next cycle.
  - seg_word may change while seg_ready=0; it is ignored.
- Frame boundary:
  - Occurs on the last cycle of digit NUM_DIGITS-1's slot, and on every cycle in IDLE.
  - At a boundary: if pending, active <= shadow and pending <= 0 (seg_ready=1 next cycle).
  - A transfer and a boundary in the same cycle: the incoming word lands in the shadow and is not applied until the next boundary.
- States:
  - IDLE: enable=0; pins inactive, counters held at 0. Next is BLANK when enable=1.
  - BLANK: tick_cnt in [0, BLANK_TICKS-1]; all digits off, segments inactive. Skipped when BLANK_TICKS=0.
  - SHOW: tick_cnt in [BLANK_TICKS, DIGIT_TICKS-1]; dig_pins[digit] active, seg_pins = active byte[digit], polarity applied.
  - End of slot: tick_cnt wraps to 0 and digit increments, wrapping NUM_DIGITS-1 -> 0 (frame boundary), then BLANK.
- Timing:
  - Pins are registered and lag the state by exactly 1 cycle.
  - Each digit is lit for exactly DIGIT_TICKS-BLANK_TICKS consecutive cycles per frame.
  - Frame period = NUM_DIGITS*DIGIT_TICKS cycles.
- frame_tick:
  - Asserts on the cycle the digit-0 slot begins: on leaving IDLE, and after each wrap.
  - Aligned with the first BLANK cycle of digit 0 on the pins.
- enable deasserted mid-frame: IDLE next cycle, pins inactive on the following cycle, no partial-slot completion. Re-enable starts at digit 0, tick 0.
- Reset mid-operation: immediate return to reset values; a pending shadow word is discarded.
- Counter widths: clog2(DIGIT_TICKS) and clog2(NUM_DIGITS), minimum 1 bit.

Decomposition:
- Shared display package holds:
  - Segment bit positions (SEG_A=7 ... SEG_DP=0).
  - Digit glyph constants 0-9 (e.g. ZERO=8'hFC, ONE=8'h60, EIGHT=8'hFE), shared with the segment decoder and the bench.
  - The BLANK/SHOW/IDLE state enum.
- One natural sub-module: seg_scan_timer, the tick/digit counter pair emitting phase (blank/show), digit index and frame wrap. Handshake, shadow register and pin registers stay in seg_scan.

Test Plan:
- Bench parameters: NUM_DIGITS=4, DIGIT_TICKS=8, BLANK_TICKS=2, active-low.
- Reset then enable=1, no word: dig_pins cycles 1110, 1101, 1011, 0111 (each low for 6 cycles after 2 all-high cycles); seg_pins=8'hFF throughout; frame_tick every 32 cycles.
- Load word 32'hFE_60_FC_DA mid-frame: seg_ready drops next cycle. Current frame still shows blank. Next frame: digit0=~8'hDA=8'h25, digit1=8'h03, digit2=8'h9F, digit3=8'h01. seg_ready returns 1 after the boundary.
- Hold seg_valid continuously, changing the word each cycle: exactly one transfer per frame, and each displayed frame is internally consistent (all four bytes from one transfer).
- Transfer on the frame-boundary cycle: the word appears one full frame later, not immediately.
- Deassert enable during the digit-2 SHOW phase: all pins high 2 cycles later. Re-enable: frame_tick pulses, digit 0 BLANK first, 2 blank cycles then 6 lit.
- Assert rst_n=0 asynchronously mid-SHOW with a word pending: pins go inactive without waiting for a clock edge; after release seg_ready=1 and the display shows blank.
